memory_unit: RTL and testbench
==============================

MEMORY_UNIT -- requirements
Module: memory_unit

Interface
REQ-001 Parameter WAIT_CYCLES, default 2, number of ACCESS-state cycles per transfer, legal range 0..15.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 control_signal  input  32  CPU control word; bit 11 = read request, bit 12 = write request, other bits ignored.
REQ-005 from_MAR  input  8  access address from the memory address register.
REQ-006 from_MBR  input  16  write data from the memory buffer register.
REQ-007 to_MBR  output  16  read data returned to the memory buffer register.
REQ-008 mem_ready  output  1  one-cycle completion strobe for the current read or write.
REQ-009 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-010 Storage SHALL be 256 words x 16 bits, indexed by the captured 8-bit address; every address is valid, with no wrap logic needed.
REQ-011 FSM states SHALL be IDLE, ACCESS and DONE, encoded in a registered state variable.
REQ-012 In IDLE, a rising edge with bit 11 or bit 12 high SHALL accept the request, capturing from_MAR, from_MBR and the operation type.
REQ-013 If bits 11 and 12 are both high in IDLE, the request SHALL be treated as a write.
REQ-014 On acceptance, if WAIT_CYCLES > 0, the FSM SHALL enter ACCESS and load the wait counter with WAIT_CYCLES-1; if WAIT_CYCLES = 0, the FSM SHALL go directly to DONE.
REQ-015 In ACCESS, the counter SHALL decrement each cycle; on the cycle the counter is 0, the FSM SHALL move to DONE.
REQ-016 Write: the array word at the captured address SHALL be updated with the captured data on the transition into DONE.
REQ-017 Read: to_MBR SHALL be loaded from the array at the captured address on the transition into DONE.
REQ-018 to_MBR SHALL hold its value until the next read completes; writes SHALL NOT change to_MBR.
REQ-019 A read of an address written earlier SHALL return the new data.
REQ-020 mem_ready SHALL be high for exactly the one cycle the FSM is in DONE.
REQ-021 DONE SHALL always return to IDLE on the next edge.
REQ-022 Request bits sampled in ACCESS or DONE SHALL be ignored, with no queuing.
REQ-023 A request still held high when the FSM returns to IDLE SHALL start a new transfer.
REQ-024 Completion latency SHALL be WAIT_CYCLES+1 cycles from the accepting edge to the mem_ready-high cycle.
REQ-025 Changes on from_MAR or from_MBR after acceptance SHALL NOT affect the transfer in progress.
REQ-026 busy SHALL be high in ACCESS and DONE and low in IDLE.

Reset
REQ-027 When rst is high at an edge, the FSM SHALL go to IDLE, with counter = 0, to_MBR = 16'h0000, mem_ready = 0 and busy = 0.
REQ-028 rst SHALL take priority over any request on the same edge.
REQ-029 Reset during ACCESS SHALL abort the transfer: no array write and no mem_ready strobe.
REQ-030 Reset SHALL NOT clear array contents.

Verification
REQ-031 Reset: assert rst for 2 cycles with bit 12 high -> to_MBR = 0000, mem_ready = 0, busy = 0, and no write.
REQ-032 Write then read, WAIT_CYCLES = 2:
- write 16'hBEEF to address 8'h3C -> mem_ready high 3 cycles after acceptance;
- read 8'h3C -> to_MBR = BEEF with mem_ready, held after.
REQ-033 Simultaneous request bits: bits 11 and 12 high, address 8'hFF, data 16'h1234 -> acts as write; a later read of 8'hFF returns 1234, and to_MBR is unchanged by the write.
REQ-034 Busy ignore:
- issue read of 8'h10 (preloaded 0x0A0A);
- pulse a write of 0x5555 to 8'h10 during ACCESS only;
- expect: write ignored, read returns 0A0A, 8'h10 still 0A0A.
REQ-035 Reset mid-access: write 0x7777 to 8'h20 (old value 0x0001), rst asserted in first ACCESS cycle -> no mem_ready, and 8'h20 reads back 0001.
REQ-036 WAIT_CYCLES = 0 with read held high continuously -> mem_ready strobes every 2nd cycle (accept, DONE, IDLE re-accept pattern), and busy toggles accordingly.

Source files
------------

// File: rtl/memory_unit.sv
// memory_unit: 256 x 16 word store behind an IDLE/ACCESS/DONE handshake FSM.
// A request is captured in IDLE. The transfer completes after WAIT_CYCLES
// access cycles, and completion is signalled by a one-cycle mem_ready strobe.
module memory_unit #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] control_signal,
  input  logic [7:0]  from_MAR,
  input  logic [15:0] from_MBR,
  output logic [15:0] to_MBR,
  output logic        mem_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } req_t;

  localparam logic [3:0] LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t      state;
  logic [3:0]  count;
  req_t        cap;
  logic [15:0] mem [256];

  logic        req_rd, req_wr, accept, finish, x_wr, mem_we;
  logic [7:0]  x_addr;
  logic [15:0] x_data;

  // Only bits 11/12 of the control word matter.
  logic unused_ctrl;
  assign unused_ctrl = ^{control_signal[31:13], control_signal[10:0]};

  // Resolve the transfer that completes this edge. With zero wait cycles it
  // finishes on the accepting edge itself, so the live inputs are used.
  always_comb begin
    req_rd = control_signal[11];
    req_wr = control_signal[12];
    accept = (state == IDLE) && (req_rd || req_wr);
    finish = ((state == ACCESS) && (count == 4'd0)) ||
             (accept && (WAIT_CYCLES == 0));
    x_addr = (state == IDLE) ? from_MAR : cap.addr;
    x_data = (state == IDLE) ? from_MBR : cap.data;
    x_wr   = (state == IDLE) ? req_wr   : cap.wr;
    mem_we = !rst && finish && x_wr;
  end

  // Array write. It has no reset, so contents survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) mem[x_addr] <= x_data;
  end

  // Handshake FSM with registered outputs and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      cap       <= '0;
      to_MBR    <= 16'h0000;
      mem_ready <= 1'b0;
      busy      <= 1'b0;
    end else begin
      mem_ready <= finish;
      case (state)
        IDLE: begin
          if (accept) begin
            cap  <= '{wr: req_wr, addr: from_MAR, data: from_MBR};
            busy <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state <= DONE;
            end else begin
              state <= ACCESS;
              count <= LOAD;
            end
          end
        end
        ACCESS: begin
          if (count == 4'd0) state <= DONE;
          else               count <= count - 4'd1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
      if (finish && !x_wr) to_MBR <= mem[x_addr];
    end
  end

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed table plus randomized transfers against a
// word-array reference model. One DUT uses WAIT_CYCLES=2, the other uses 0.
module tb_memory_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ctrl = '0, ctrl0 = '0;
  logic [7:0]  mar = '0, mar0 = '0;
  logic [15:0] mbr = '0, mbr0 = '0;
  logic [15:0] rd, rd0;
  logic        rdy, rdy0, bsy, bsy0;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] ref_mem [256];
  bit          ref_vld [256];
  logic [15:0] ref_rd = 16'h0000;

  memory_unit #(.WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .control_signal(ctrl), .from_MAR(mar),
    .from_MBR(mbr), .to_MBR(rd), .mem_ready(rdy), .busy(bsy));

  memory_unit #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .control_signal(ctrl0), .from_MAR(mar0),
    .from_MBR(mbr0), .to_MBR(rd0), .mem_ready(rdy0), .busy(bsy0));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Build a control word: request bits plus random noise elsewhere.
  function automatic logic [31:0] mk(input bit r, input bit w);
    logic [31:0] c;
    c = $urandom;
    c[11] = r;
    c[12] = w;
    return c;
  endfunction

  // One transfer on the WAIT_CYCLES=2 DUT. The inputs are scrambled after
  // acceptance, the reference model is updated, and latency and data are checked.
  task automatic xfer(input bit r, input bit w, input logic [7:0] a, input logic [15:0] d, input string tag);
    int lat;
    ctrl = mk(r, w); mar = a; mbr = d;
    step();
    check({tag, "_busy"}, 32'(bsy), 32'd1);
    ctrl = mk(0, 0); mar = 8'($urandom); mbr = 16'($urandom);
    lat = 1;
    while (!rdy && lat < 20) begin step(); lat++; end
    if (w) begin ref_mem[a] = d; ref_vld[a] = 1; end
    else ref_rd = ref_mem[a];
    check({tag, "_lat"}, 32'(lat), 32'd3);
    check({tag, "_rd"}, 32'(rd), 32'(ref_rd));
    step();
    check({tag, "_idle"}, {30'd0, bsy, rdy}, 32'd0);
  endtask

  typedef struct {
    bit          r, w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [15:0] exp_rd;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{r:0, w:1, a:8'h3C, d:16'hBEEF, exp_rd:16'h0000};
    vecs[1] = '{r:1, w:0, a:8'h3C, d:16'h0000, exp_rd:16'hBEEF};
    vecs[2] = '{r:1, w:1, a:8'hFF, d:16'h1234, exp_rd:16'hBEEF};
    vecs[3] = '{r:1, w:0, a:8'hFF, d:16'h0000, exp_rd:16'h1234};
    vecs[4] = '{r:0, w:1, a:8'h10, d:16'h0A0A, exp_rd:16'h1234};
    vecs[5] = '{r:0, w:1, a:8'h20, d:16'h0001, exp_rd:16'h1234};
    vecs[6] = '{r:0, w:1, a:8'h55, d:16'hAAAA, exp_rd:16'h1234};

    // Reset held two cycles with a write request pending.
    ctrl = mk(0, 1); mar = 8'h3C; mbr = 16'hDEAD;
    step(); step();
    check("rst_outs", {rd, 14'd0, rdy, bsy}, 32'd0);
    ctrl = mk(0, 0); rst = 1'b0;
    step();

    // Directed table.
    for (int i = 0; i < 7; i++) begin
      xfer(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_tbl", i), 32'(rd), 32'(vecs[i].exp_rd));
    end

    // Reset with a write held must not write.
    rst = 1'b1; ctrl = mk(0, 1); mar = 8'h55; mbr = 16'h9999;
    step(); step();
    check("rst2_outs", {rd, 14'd0, rdy, bsy}, 32'd0);
    rst = 1'b0; ctrl = mk(0, 0); ref_rd = 16'h0000;
    step();
    xfer(1, 0, 8'h55, 16'h0, "rst_nowrite");

    // A write pulsed during ACCESS is ignored.
    ctrl = mk(1, 0); mar = 8'h10;
    step();
    ctrl = mk(0, 1); mar = 8'h10; mbr = 16'h5555;
    step(); step();
    check("ign_ready", 32'(rdy), 32'd1);
    check("ign_rd", 32'(rd), 32'h0A0A);
    ctrl = mk(0, 0); ref_rd = 16'h0A0A;
    step();
    check("ign_idle", 32'(bsy), 32'd0);
    xfer(1, 0, 8'h10, 16'h0, "ign_mem");

    // Reset in the first ACCESS cycle aborts the write.
    ctrl = mk(0, 1); mar = 8'h20; mbr = 16'h7777;
    step();
    rst = 1'b1; ctrl = mk(0, 0);
    begin
      int seen = 0;
      for (int i = 0; i < 4; i++) begin step(); seen += int'(rdy); end
      check("abort_noready", 32'(seen), 32'd0);
    end
    rst = 1'b0; ref_rd = 16'h0000;
    step();
    xfer(1, 0, 8'h20, 16'h0, "abort_mem");

    // Randomized transfers against the model.
    for (int i = 0; i < 40; i++) begin
      bit w, r;
      logic [7:0] a;
      a = 8'($urandom);
      w = ($urandom_range(0, 1) == 1) || !ref_vld[a];
      r = w ? ($urandom_range(0, 3) == 0) : 1'b1;
      xfer(r, w, a, 16'($urandom), $sformatf("rnd%0d", i));
    end

    // WAIT_CYCLES=0: write, then hold a read continuously.
    ctrl0 = mk(0, 1); mar0 = 8'h05; mbr0 = 16'hC0DE;
    step();
    check("w0_wr_ready", {30'd0, rdy0, bsy0}, 32'd3);
    check("w0_wr_rd", 32'(rd0), 32'h0000);
    ctrl0 = mk(1, 0);
    step();
    check("w0_idle", {30'd0, rdy0, bsy0}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      bit on;
      step();
      on = (i % 2) == 0;
      check($sformatf("w0_rdy%0d", i), 32'(rdy0), 32'(on));
      check($sformatf("w0_bsy%0d", i), 32'(bsy0), 32'(on));
      check($sformatf("w0_data%0d", i), 32'(rd0), 32'hC0DE);
      ctrl0 = mk(1, 0); mar0 = 8'h05;
    end
    ctrl0 = mk(0, 0);
    step(); step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
